// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: command/state encodings, TAP constants, target opcodes.
package jtag_pkg;

  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_IR    = 2'd1,
    CMD_DR    = 2'd2
  } jtag_cmd_e;

  // Target TAP state as tracked by the master; ST_RESET_SEQ covers the TMS=1 run
  typedef enum logic [3:0] {
    ST_TLR,
    ST_IDLE,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE,
    ST_RESET_SEQ
  } jtag_mst_state_e;

  localparam int JTAG_TLR_TMS_CNT  = 5;
  localparam int JTAG_TRST_TCK_CNT = 2;

  localparam int IR_LEN = 4;
  localparam logic [IR_LEN-1:0] IR_EXTEST = 4'h0;
  localparam logic [IR_LEN-1:0] IR_IDCODE = 4'h1;
  localparam logic [IR_LEN-1:0] IR_SAMPLE = 4'h2;
  localparam logic [IR_LEN-1:0] IR_BYPASS = 4'hF;
  localparam logic [31:0]       IDCODE_VALUE = 32'h4BA0_0477;

endpackage

// File: rtl/jtag_tck_gen.sv
// Free-running CLK_DIV divider. Strobes mark the clk on which tck would rise/fall;
// tck itself only toggles while en is high and idles low otherwise.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          ph;
  logic          wrap;

  assign wrap     = (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = wrap & ~ph;
  assign fall_stb = wrap & ph;

  // Half-period counter, phase toggle and gated tck register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ph  <= 1'b0;
      tck <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) ph <= ~ph;
      tck <= en & (wrap ? ~ph : ph);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG driver: runs TAP reset / IR scan / DR scan commands and returns TDO.
// Optional JTAG_MASTER_TRST_EN: CMD_RESET pulses trst_n low for two TCKs first.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  jtag_cmd_e          cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst_n,
  input  logic               tdo
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef JTAG_MASTER_TRST_EN
  localparam int RST_TCKS = JTAG_TRST_TCK_CNT + JTAG_TLR_TMS_CNT;
`else
  localparam int RST_TCKS = JTAG_TLR_TMS_CNT;
`endif

  jtag_mst_state_e    state, state_nxt;
  jtag_cmd_e          typ;
  logic [LEN_W-1:0]   len, len_clamp, bit_cnt;
  logic [MAX_LEN-1:0] data, cap;
  logic [2:0]         rst_cnt;
  logic               busy, run, done;
  logic               accept, rise, fall;
  logic               tms_nxt, tdi_nxt;

  assign accept    = cmd_valid & cmd_ready;
  assign len_clamp = (cmd_len == '0)                  ? LEN_W'(1) :
                     (cmd_len > LEN_W'(MAX_LEN))      ? LEN_W'(MAX_LEN) : cmd_len;

  // run gates tck so the first edge seen by the target is a rise after tms is set up
  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .tck      (tck),
    .rise_stb (rise),
    .fall_stb (fall)
  );

  // Tracked TAP state advances on the rise strobe, like the target's TAP
  always_ff @(posedge clk) begin
    if (reset)             state <= ST_TLR;
    else if (run && rise)  state <= state_nxt;
  end

  // Pin values for the coming TCK and the TAP transition taken on its rise
  always_comb begin
    tms_nxt   = tms;
    tdi_nxt   = 1'b0;
    state_nxt = state;
    if (typ == CMD_RESET) begin
      tms_nxt   = 1'b1;
      state_nxt = (rst_cnt == 3'(RST_TCKS - 1)) ? ST_TLR : ST_RESET_SEQ;
    end else begin
      case (state)
        ST_TLR:     begin tms_nxt = 1'b0;              state_nxt = tms ? ST_TLR    : ST_IDLE;    end
        ST_IDLE:    begin tms_nxt = 1'b1;              state_nxt = tms ? ST_SEL_DR : ST_IDLE;    end
        ST_SEL_DR:  begin tms_nxt = (typ == CMD_IR);   state_nxt = tms ? ST_SEL_IR : ST_CAPTURE; end
        ST_SEL_IR:  begin tms_nxt = 1'b0;              state_nxt = tms ? ST_TLR    : ST_CAPTURE; end
        ST_CAPTURE: begin tms_nxt = 1'b0;              state_nxt = tms ? ST_EXIT1  : ST_SHIFT;   end
        ST_SHIFT: begin
          tms_nxt   = (bit_cnt == len - 1'b1);
          tdi_nxt   = data[bit_cnt[IDX_W-1:0]];
          state_nxt = tms ? ST_EXIT1 : ST_SHIFT;
        end
        ST_EXIT1:   begin tms_nxt = 1'b1;              state_nxt = ST_UPDATE;                    end
        ST_UPDATE:  begin tms_nxt = 1'b0;              state_nxt = tms ? ST_SEL_DR : ST_IDLE;    end
        default:    begin tms_nxt = 1'b1;              state_nxt = ST_TLR;                       end
      endcase
    end
  end

  // Command capture, pin updates on fall, TDO capture on rise, completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      run       <= 1'b0;
      done      <= 1'b0;
      typ       <= CMD_RESET;
      len       <= '0;
      data      <= '0;
      cap       <= '0;
      bit_cnt   <= '0;
      rst_cnt   <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      cmd_ready <= ~(busy | accept);
      if (accept) begin
        busy    <= 1'b1;
        done    <= 1'b0;
        typ     <= cmd_type;
        len     <= len_clamp;
        data    <= cmd_data;
        cap     <= '0;
        bit_cnt <= '0;
        rst_cnt <= '0;
      end
      if (busy && fall) begin
        if (done) begin
          busy      <= 1'b0;
          run       <= 1'b0;
          tdi       <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= cap;
        end else begin
          run <= 1'b1;
          tms <= tms_nxt;
          tdi <= tdi_nxt;
        end
      end
      if (run && rise) begin
        if (state == ST_SHIFT) begin
          cap[bit_cnt[IDX_W-1:0]] <= tdo;
          bit_cnt                 <= bit_cnt + 1'b1;
        end
        if (typ == CMD_RESET) rst_cnt <= rst_cnt + 1'b1;
        done <= (typ == CMD_RESET) ? (rst_cnt == 3'(RST_TCKS - 1)) : (state == ST_UPDATE);
      end
    end
  end

`ifdef JTAG_MASTER_TRST_EN
  // trst_n low for the first two TCKs of a reset command, changing with tms
  always_ff @(posedge clk) begin
    if (reset)
      trst_n <= 1'b1;
    else if (busy && fall && !done)
      trst_n <= !(typ == CMD_RESET && rst_cnt < 3'(JTAG_TRST_TCK_CNT));
  end
`else
  assign trst_n = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: vector table, target TAP model, abort sequence, random scans.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
`ifdef JTAG_MASTER_TRST_EN
  localparam int RST_TCKS  = 7;
  localparam int TRST_CLKS = 4 * CLK_DIV;
`else
  localparam int RST_TCKS  = 5;
  localparam int TRST_CLKS = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  jtag_cmd_e          cmd_type = CMD_RESET;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck, tms, tdi, trst_n, tdo;
  logic               loopback = 1'b1;
  logic               tgt_tdo;

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tck(tck), .tms(tms), .tdi(tdi),
    .trst_n(trst_n), .tdo(tdo)
  );

  always #5 clk = ~clk;
  assign tdo = loopback ? tdi : tgt_tdo;

  // ---------------- target TAP model (IEEE 1149.1 state table) ----------------
  typedef enum logic [3:0] {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                            T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_e;
  tap_e              ts = T_TLR;
  logic [IR_LEN-1:0] ir = IR_IDCODE;
  logic [IR_LEN-1:0] ir_sr = '0;
  logic [31:0]       dr_sr = '0;
  int                dr_w = 1;

  function automatic tap_e tap_step(input tap_e s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    if (!trst_n) begin
      ts <= T_TLR;
      ir <= IR_IDCODE;
    end else begin
      case (ts)
        T_TLR:  ir <= IR_IDCODE;
        T_CDR:  begin dr_sr <= (ir == IR_IDCODE) ? IDCODE_VALUE : 32'h0; dr_w <= (ir == IR_IDCODE) ? 32 : 1; end
        T_SHDR: dr_sr <= (dr_sr >> 1) | (32'(tdi) << (dr_w - 1));
        T_CIR:  ir_sr <= IR_LEN'(1);
        T_SHIR: ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
        T_UIR:  ir <= ir_sr;
        default: ;
      endcase
      ts <= tap_step(ts, tms);
    end
  end

  always_comb tgt_tdo = (ts == T_SHDR) ? dr_sr[0] : (ts == T_SHIR) ? ir_sr[0] : 1'b0;

  // ---------------- monitors (sole writers of their counters) ----------------
  int   tck_total = 0, rsp_total = 0, trst_total = 0;
  logic tms_hist [0:8191];
  always @(posedge tck) begin
    tms_hist[tck_total % 8192] = tms;
    tck_total++;
  end
  always @(posedge clk) begin
    if (rsp_valid) rsp_total++;
    if (!trst_n)   trst_total++;
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_err = 0;
  bit at_tlr = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int clampl(input logic [LEN_W-1:0] l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return int'(l);
  endfunction

  function automatic logic [31:0] loop_rsp(input jtag_cmd_e t, input logic [LEN_W-1:0] l, input logic [31:0] d);
    logic [63:0] m;
    if (t == CMD_RESET) return 32'h0;
    m = (64'd1 << clampl(l)) - 64'd1;
    return d & m[31:0];
  endfunction

  // TMS sequence from the command rules: prefix, select, capture, N shift bits, update, RTI
  function automatic void exp_tms(input jtag_cmd_e t, input int n, input bit tlr,
                                  output logic [63:0] p, output int cnt);
    p = '0; cnt = 0;
    if (t == CMD_RESET) begin
      for (int i = 0; i < RST_TCKS; i++) begin p[cnt] = 1'b1; cnt++; end
      return;
    end
    if (tlr) cnt++;
    p[cnt] = 1'b1; cnt++;
    if (t == CMD_IR) begin p[cnt] = 1'b1; cnt++; end
    cnt += 2 + n - 1;
    p[cnt] = 1'b1; cnt++;
    p[cnt] = 1'b1; cnt++;
    cnt++;
  endfunction

  task automatic do_cmd(input string nm, input jtag_cmd_e t, input logic [LEN_W-1:0] l,
                        input logic [31:0] d, input logic [31:0] er, input int et);
    logic [63:0] p, got;
    int pc, cyc, b_tck, b_rsp, b_trst, nt;
    exp_tms(t, clampl(l), at_tlr, p, pc);
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin @(negedge clk); cyc++; end
    chk({nm, " ready"}, 64'(cmd_ready), 64'd1);
    b_tck = tck_total; b_rsp = rsp_total; b_trst = trst_total;
    cmd_valid = 1'b1; cmd_type = t; cmd_len = l; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = $urandom; cmd_len = LEN_W'($urandom);
    chk({nm, " busy"}, 64'(cmd_ready), 64'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 1000) begin @(negedge clk); cyc++; end
    chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, " rsp_data"}, 64'(rsp_data), 64'(er));
    @(negedge clk);
    chk({nm, " ready_after"}, {62'd0, rsp_valid, cmd_ready}, 64'd1);
    chk({nm, " rsp_pulses"}, 64'(rsp_total - b_rsp), 64'd1);
    nt = tck_total - b_tck;
    chk({nm, " tcks"}, 64'(nt), 64'(et));
    got = '0;
    for (int i = 0; i < nt && i < 64; i++) got[i] = tms_hist[(b_tck + i) % 8192];
    chk({nm, " tms_seq"}, got, p);
    chk({nm, " trst_clks"}, 64'(trst_total - b_trst), 64'((t == CMD_RESET) ? TRST_CLKS : 0));
    at_tlr = (t == CMD_RESET);
  endtask

  typedef struct {
    jtag_cmd_e        t;
    logic [LEN_W-1:0] len;
    logic [31:0]      data;
    logic [31:0]      rsp;
    int               tcks;
  } vec_t;

  vec_t vt [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    int pc, cyc, b_tck, b_rsp;
    jtag_cmd_e rt;
    logic [LEN_W-1:0] rl;
    logic [31:0] rd;

    // loopback vectors, starting from TLR right after reset
    vt[0] = '{CMD_DR,    6'd4,  32'hFFFF_FFF3, 32'h0000_0003, 10};
    vt[1] = '{CMD_DR,    6'd8,  32'h0000_00A5, 32'h0000_00A5, 13};
    vt[2] = '{CMD_DR,    6'd1,  32'h0000_0001, 32'h0000_0001, 6};
    vt[3] = '{CMD_DR,    6'd32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 37};
    vt[4] = '{CMD_DR,    6'd0,  32'hFFFF_FFFF, 32'h0000_0001, 6};
    vt[5] = '{CMD_IR,    6'd5,  32'hFFFF_FFF5, 32'h0000_0015, 11};
    vt[6] = '{CMD_DR,    6'd63, 32'h1234_5678, 32'h1234_5678, 37};
    vt[7] = '{CMD_RESET, 6'd9,  32'hDEAD_BEEF, 32'h0000_0000, RST_TCKS};
    vt[8] = '{CMD_IR,    6'd3,  32'h0000_0006, 32'h0000_0006, 10};
    vt[9] = '{CMD_RESET, 6'd0,  32'hFFFF_FFFF, 32'h0000_0000, RST_TCKS};

    // reset values
    repeat (4) @(negedge clk);
    chk("reset pins", {58'd0, tck, tms, tdi, trst_n, cmd_ready, rsp_valid}, 64'b010100);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready after reset", 64'(cmd_ready), 64'd1);
    repeat (20) @(negedge clk);
    chk("idle tck", 64'(tck_total), 64'd0);

    for (int i = 0; i < 10; i++)
      do_cmd($sformatf("vec%0d", i), vt[i].t, vt[i].len, vt[i].data, vt[i].rsp, vt[i].tcks);

    // target TAP: IR capture pattern, IDCODE readout, bypass delay
    loopback = 1'b0;
    do_cmd("tgt reset", CMD_RESET, 6'd0, 32'h0, 32'h0, RST_TCKS);
    do_cmd("tgt ir_idcode", CMD_IR, 6'(IR_LEN), 32'(IR_IDCODE), 32'h1, IR_LEN + 7);
    do_cmd("tgt idcode", CMD_DR, 6'd32, 32'h0, IDCODE_VALUE, 37);
    do_cmd("tgt ir_bypass", CMD_IR, 6'(IR_LEN), 32'(IR_BYPASS), 32'h1, IR_LEN + 6);
    do_cmd("tgt bypass", CMD_DR, 6'd8, 32'hA5, 32'h4A, 13);
    loopback = 1'b1;

    // reset in the middle of a 32-bit shift
    b_tck = tck_total; b_rsp = rsp_total;
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin @(negedge clk); cyc++; end
    cmd_valid = 1'b1; cmd_type = CMD_DR; cmd_len = 6'd32; cmd_data = 32'hCAFE_F00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (tck_total - b_tck < 15 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("abort reached shift", 64'(tck_total - b_tck >= 15), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort pins", {60'd0, tck, tms, cmd_ready, rsp_valid}, 64'b0100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort no rsp", 64'(rsp_total - b_rsp), 64'd0);
    at_tlr = 1'b1;
    do_cmd("after abort", CMD_DR, 6'd8, 32'h5A, 32'h5A, 14);

    // random commands against the loopback model
    for (int i = 0; i < 24; i++) begin
      rt = jtag_cmd_e'(2'($urandom_range(0, 2)));
      rl = LEN_W'($urandom_range(0, 40));
      rd = $urandom;
      exp_tms(rt, clampl(rl), at_tlr, p, pc);
      do_cmd($sformatf("rnd%0d", i), rt, rl, rd, loop_rsp(rt, rl, rd), pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG driver; the initiator at the opposite end of the cable from the jtag_top TAP.
- Accepts scan commands (TAP reset, IR scan, DR scan) on a valid/ready interface, runs on the system clock and generates TCK/TMS/TDI/TRST_N.
- Samples TDO and returns the captured bits on a response interface.
- Used by on-chip BIST/debug logic and by FPGA test harnesses to drive jtag_top.

Parameters:
- CLK_DIV, 4, clk cycles per TCK half-period; legal range 2..255.
- MAX_LEN, 32, maximum scan length in bits; also the width of the data buses.
- LEN_W, $clog2(MAX_LEN+1), width of cmd_len.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_type  in  2  jtag_cmd_e: CMD_RESET, CMD_IR, CMD_DR.
- cmd_len  in  LEN_W  scan length in bits, 1..MAX_LEN; ignored for CMD_RESET.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  single-cycle pulse; rsp_data valid.
- rsp_data  out  MAX_LEN  captured TDO bits, right-aligned, first bit in bit 0, upper bits 0.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to the target.
- trst_n  out  1  JTAG async reset to the target, active low.
- tdo  in  1  JTAG data from the target; synchronised externally.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, trst_n=1, cmd_ready=0, rsp_valid=0, rsp_data=0. cmd_ready rises one clk after reset deasserts.
- Tracked TAP state after reset is TLR.
- Reset asserted mid-command aborts it: no rsp_valid, outputs return to reset values on the next edge.
- TCK generation:
  - Divider counter produces a rise strobe and a fall strobe. TCK period = 2*CLK_DIV clk; idles low.
  - tms/tdi update only on the fall strobe.
  - tdo is sampled on the clk of the rise strobe.
- Handshake:
  - Command is accepted on cmd_valid && cmd_ready. cmd_data, cmd_len and cmd_type are registered at acceptance.
  - cmd_ready stays 0 until rsp_valid has pulsed (RESET and scans alike).
  - cmd_len=0 or cmd_len>MAX_LEN is clamped to 1 and MAX_LEN respectively.
- FSM states: ST_TLR, ST_IDLE(RTI), ST_SEL_DR, ST_SEL_IR, ST_CAPTURE, ST_SHIFT, ST_EXIT1, ST_UPDATE, ST_RESET_SEQ.
- Each state lasts exactly one TCK period. The state advances on the rise strobe, mirroring the target TAP.
- CMD_DR TMS sequence, one TCK per bit:
  - 1 (SEL_DR), 0 (CAPTURE), 0 (enter SHIFT), then N bits with TMS=0 except the last bit, which has TMS=1 (EXIT1).
  - Then 1 (UPDATE), 0 (RTI).
  - Total N+5 TCKs from RTI.
- CMD_IR: same as CMD_DR with an extra leading 1 (SEL_DR→SEL_IR). Total N+6 TCKs.
- Scan from ST_TLR: one TMS=0 TCK is prepended to reach RTI.
- TDI during SHIFT: bit k of cmd_data is driven in the TCK whose rise edge shifts bit k. tdi=0 outside SHIFT.
- TDO: sampled on each of the N SHIFT rise edges into rsp_data[k].
- Completion: rsp_valid pulses for one clk on the fall strobe after the UPDATE→RTI rise edge. cmd_ready returns to 1 the following clk.
- CMD_RESET: 5 TCKs with TMS=1, end in ST_TLR, rsp_valid with rsp_data=0.
- Back-to-back commands: a new command accepted in ST_IDLE starts on the next fall strobe. There are no extra RTI cycles beyond the one in each sequence.

Optional Feature:
- Macro: JTAG_MASTER_TRST_EN.
- Defined: CMD_RESET first drives trst_n=0 for 2 TCK periods with TMS=1, then performs the 5-TCK TMS sequence. trst_n is registered.
- Not defined: trst_n is tied to 1 and reset is TMS-only.

Decomposition:
- jtag_pkg gains:
  - jtag_cmd_e typedef
  - jtag_mst_state_e typedef
  - JTAG_TLR_TMS_CNT=5 constant
  - the existing IR_LEN and instruction opcodes, which the bench reuses
- Natural sub-module: jtag_tck_gen, the CLK_DIV counter emitting tck, rise_stb and fall_stb, with a synchronous enable that holds tck low when idle.

Test Plan:
- Reset → all outputs at reset values. Release → cmd_ready=1 after 1 clk; tck stays 0 with no command.
- CMD_RESET → 5 TCK periods of tms=1 (each 8 clk at CLK_DIV=4), rsp_valid once with rsp_data=0. With JTAG_MASTER_TRST_EN, a 16-clk trst_n low pulse precedes it.
- Loopback tdo=tdi, CMD_DR len=8 data=0xA5 → exactly 13 TCKs, TMS pattern 1,0,0,0000000,1,1,0, rsp_data=0x000000A5.
- Connect to jtag_top: CMD_IR len=IR_LEN with the IDCODE opcode, then CMD_DR len=32 → rsp_data equals the jtag_top IDCODE value; the first IR scan returns the capture pattern 'b01 in the low bits.
- Edge lengths: CMD_DR len=1 → TMS=1 on the only SHIFT bit, 6 TCKs. len=MAX_LEN with data 0xFFFFFFFF in loopback → rsp_data 0xFFFFFFFF. len=0 → behaves as len=1.
- Reset asserted mid-SHIFT of a len=32 scan → no rsp_valid, tck=0 and tms=1 next clk. A subsequent CMD_DR starts with the TLR→RTI TMS=0 prefix.
